// File: rtl/ext_pwr_domain_ctrl.sv
// ext_pwr_domain_ctrl
//   Power-gating sequencer for one external (CGRA-side) power domain.
//   It sequences isolation, clock gate, domain reset and the switch-cell
//   enable for power-down, and the reverse order for power-up. It waits on
//   a synchronized switch-cell acknowledge and flags a sticky timeout when
//   the acknowledge is late.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   pwr_off_req_i  level request: 1 = domain off, 0 = domain on
//   switch_ack_i   asynchronous switch-cell acknowledge
//   clr_timeout_i  pulse that clears timeout_o
//   switch_en_o    1 = switch cells conducting
//   iso_en_o       1 = domain outputs clamped
//   clk_en_o       1 = domain clock enabled
//   domain_rst_no  active-low reset to the domain
//   powered_o      1 only when the domain is fully on
//   busy_o         1 while a sequence is in progress
//   timeout_o      sticky acknowledge-timeout flag
module ext_pwr_domain_ctrl #(
    parameter int unsigned ISO_CYCLES  = 2,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwr_off_req_i,
    input  logic switch_ack_i,
    input  logic clr_timeout_i,
    output logic switch_en_o,
    output logic iso_en_o,
    output logic clk_en_o,
    output logic domain_rst_no,
    output logic powered_o,
    output logic busy_o,
    output logic timeout_o
);

    localparam logic [3:0] ST_ON      = 4'd0;
    localparam logic [3:0] ST_ISO_ON  = 4'd1;
    localparam logic [3:0] ST_CLK_OFF = 4'd2;
    localparam logic [3:0] ST_RST_ON  = 4'd3;
    localparam logic [3:0] ST_SW_OFF  = 4'd4;
    localparam logic [3:0] ST_OFF     = 4'd5;
    localparam logic [3:0] ST_SW_ON   = 4'd6;
    localparam logic [3:0] ST_CLK_ON  = 4'd7;
    localparam logic [3:0] ST_RST_OFF = 4'd8;
    localparam logic [3:0] ST_ISO_OFF = 4'd9;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(ACK_TIMEOUT);

    logic [3:0]             state_q;
    logic [3:0]             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   in_wait;
    logic                   ack_late;
    logic                   sw_d;
    logic                   iso_d;
    logic                   clk_d;
    logic                   rst_d;
    logic                   pwr_d;
    logic                   busy_d;

    // Ack synchronizer; resets to 1 because the domain comes out of reset powered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], switch_ack_i};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ON:      if (pwr_off_req_i)      state_d = ST_ISO_ON;
            ST_ISO_ON:  if (cnt_q == ISO_LAST)  state_d = ST_CLK_OFF;
            ST_CLK_OFF:                         state_d = ST_RST_ON;
            ST_RST_ON:                          state_d = ST_SW_OFF;
            ST_SW_OFF:  if (!ack_s)             state_d = ST_OFF;
            ST_OFF:     if (!pwr_off_req_i)     state_d = ST_SW_ON;
            ST_SW_ON:   if (ack_s)              state_d = ST_CLK_ON;
            ST_CLK_ON:  if (cnt_q == RST_LAST)  state_d = ST_RST_OFF;
            ST_RST_OFF:                         state_d = ST_ISO_OFF;
            ST_ISO_OFF:                         state_d = ST_ON;
            default:                            state_d = ST_ON;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so every control changes on the same edge as the state, glitch-free.
    always_comb begin
        sw_d   = 1'b1;
        iso_d  = 1'b1;
        clk_d  = 1'b0;
        rst_d  = 1'b0;
        pwr_d  = 1'b0;
        busy_d = 1'b1;
        case (state_d)
            ST_ON: begin
                iso_d  = 1'b0;
                clk_d  = 1'b1;
                rst_d  = 1'b1;
                pwr_d  = 1'b1;
                busy_d = 1'b0;
            end
            ST_ISO_ON: begin
                clk_d = 1'b1;
                rst_d = 1'b1;
            end
            ST_CLK_OFF: rst_d = 1'b1;
            ST_RST_ON:  ;
            ST_SW_OFF:  sw_d = 1'b0;
            ST_OFF: begin
                sw_d   = 1'b0;
                busy_d = 1'b0;
            end
            ST_SW_ON:   ;
            ST_CLK_ON:  clk_d = 1'b1;
            ST_RST_OFF: begin
                clk_d = 1'b1;
                rst_d = 1'b1;
            end
            ST_ISO_OFF: begin
                iso_d = 1'b0;
                clk_d = 1'b1;
                rst_d = 1'b1;
            end
            default: begin
                iso_d  = 1'b0;
                clk_d  = 1'b1;
                rst_d  = 1'b1;
                pwr_d  = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign in_wait = (state_q == ST_ISO_ON) || (state_q == ST_CLK_ON) ||
                     (state_q == ST_SW_OFF) || (state_q == ST_SW_ON);

    // Ack still at the old level while waiting on the switch cells.
    assign ack_late = ((state_q == ST_SW_OFF) &&  ack_s) ||
                      ((state_q == ST_SW_ON)  && !ack_s);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_ON;
            cnt_q         <= '0;
            switch_en_o   <= 1'b1;
            iso_en_o      <= 1'b0;
            clk_en_o      <= 1'b1;
            domain_rst_no <= 1'b1;
            powered_o     <= 1'b1;
            busy_o        <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            switch_en_o   <= sw_d;
            iso_en_o      <= iso_d;
            clk_en_o      <= clk_d;
            domain_rst_no <= rst_d;
            powered_o     <= pwr_d;
            busy_o        <= busy_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (in_wait && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end

            // Set has priority over clear.
            if (ack_late && (cnt_q == TO_VAL)) begin
                timeout_o <= 1'b1;
            end else if (clr_timeout_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

endmodule
